// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller
//               (sequencing states, forwarding select codes, in-flight slot).
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Widest register address a slot can hold; narrower addresses zero-extend.
    localparam int c_SLOT_AW = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [c_SLOT_AW-1:0] rd;
        logic                 regwrite;
        logic                 load;
    } slot_t;

    // Empty slots are always loaded as all-zero, so any set bit means busy.
    localparam slot_t c_SLOT_NONE = '0;

    function automatic logic slot_busy(input slot_t s);
        return s != c_SLOT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pipe_scoreboard
// Description : EX/MEM/WB destination-register slot pipeline with operand
//               match and load-use detection for the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_pipe_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW             = 4,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              issue,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              ex_match_rs,
    output logic              ex_match_rt,
    output logic              mem_match_rs,
    output logic              mem_match_rt,
    output logic              load_use,
    output logic              pipe_empty
);

    slot_t r_ex;
    slot_t r_mem;
    slot_t r_wb;
    slot_t w_ex_nxt;

    function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] x,
                                        input logic used);
        return s.valid && s.regwrite && used && (s.rd == c_SLOT_AW'(x))
               && !(ZERO_REG_HARDWIRED && (x == '0));
    endfunction

    // Build the EX slot entry for the instruction leaving ID (empty if it does not issue).
    always_comb begin
        w_ex_nxt = c_SLOT_NONE;
        if (issue) begin
            w_ex_nxt.valid    = 1'b1;
            w_ex_nxt.rd       = c_SLOT_AW'(id_rd);
            w_ex_nxt.regwrite = id_regwrite;
            w_ex_nxt.load     = id_memread;
        end
    end

    // Advance the in-flight slots one stage every cycle.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_ex  <= c_SLOT_NONE;
            r_mem <= c_SLOT_NONE;
            r_wb  <= c_SLOT_NONE;
        end else begin
            r_ex  <= w_ex_nxt;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign ex_valid     = r_ex.valid;
    assign mem_valid    = r_mem.valid;
    assign ex_match_rs  = slot_match(r_ex,  id_rs, id_uses_rs);
    assign ex_match_rt  = slot_match(r_ex,  id_rt, id_uses_rt);
    assign mem_match_rs = slot_match(r_mem, id_rs, id_uses_rs);
    assign mem_match_rt = slot_match(r_mem, id_rt, id_uses_rt);
    assign load_use     = r_ex.load && (ex_match_rs || ex_match_rt);
    assign pipe_empty   = !slot_busy(r_ex) && !slot_busy(r_mem) && !slot_busy(r_wb);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage pipeline sequencing controller: stall/flush/bubble
//               enables, branch PC select, registered EX forwarding selects,
//               halt drain sequencing and a saturating load-use stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW             = 4,
    parameter bit ZERO_REG_HARDWIRED = 1'b1,
    parameter int CNT_W              = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_halt,
    input  logic              ex_branch_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pc_sel_branch,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_count;

    logic w_pc_we, w_ifid_we, w_flush, w_bubble, w_sel_branch, w_count_stall;
    logic w_issue;
    logic w_ex_valid, w_mem_valid, w_pipe_empty, w_load_use;
    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;

    hazard_ctrl_pipe_scoreboard #(
        .REG_AW             (REG_AW),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_pipe_scoreboard (
        .clk          (clk),
        .clear        (clear),
        .issue        (w_issue),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .ex_valid     (w_ex_valid),
        .mem_valid    (w_mem_valid),
        .ex_match_rs  (w_ex_rs),
        .ex_match_rt  (w_ex_rt),
        .mem_match_rs (w_mem_rs),
        .mem_match_rt (w_mem_rt),
        .load_use     (w_load_use),
        .pipe_empty   (w_pipe_empty)
    );

    // Per-state pipeline enables and next state; branch always wins over hazards and halt.
    always_comb begin
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;
        w_sel_branch  = 1'b0;
        w_count_stall = 1'b0;
        w_state_nxt   = r_state;
        case (r_state)
            RUN: begin
                if (ex_branch_taken) begin
                    {w_sel_branch, w_pc_we, w_ifid_we, w_flush, w_bubble} = 5'b11111;
                end else if (w_load_use) begin
                    w_bubble      = 1'b1;
                    w_count_stall = 1'b1;
                end else if (id_valid && id_halt) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_pc_we   = 1'b1;
                    w_ifid_we = 1'b1;
                end
            end
            DRAIN: begin
                if (ex_branch_taken) begin
                    {w_sel_branch, w_pc_we, w_ifid_we, w_flush, w_bubble} = 5'b11111;
                    w_state_nxt = RUN;
                end else begin
                    w_bubble = 1'b1;
                    // EX is always bubbled here, so the pipe is empty after the shift
                    // once EX and MEM are empty now.
                    if (!w_ex_valid && !w_mem_valid) begin
                        w_state_nxt = HALT;
                    end
                end
            end
            default: begin
                w_bubble = 1'b1;
            end
        endcase
    end

    assign w_issue = id_valid && !w_bubble;

    // Hold the pipeline safe for as long as reset is asserted.
    always_comb begin
        if (!clear) begin
            pc_we         = 1'b0;
            ifid_we       = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            pc_sel_branch = 1'b0;
        end else begin
            pc_we         = w_pc_we;
            ifid_we       = w_ifid_we;
            ifid_flush    = w_flush;
            idex_bubble   = w_bubble;
            pc_sel_branch = w_sel_branch;
        end
    end

    // State, forwarding selects for the issuing instruction, and stall counter.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state       <= RUN;
            r_fwd_a       <= FWD_RF;
            r_fwd_b       <= FWD_RF;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_fwd_a <= w_ex_rs ? FWD_EXMEM : (w_mem_rs ? FWD_MEMWB : FWD_RF);
                r_fwd_b <= w_ex_rt ? FWD_EXMEM : (w_mem_rt ? FWD_MEMWB : FWD_RF);
            end else begin
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end
            if (w_count_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign halted      = (r_state == HALT) && w_pipe_empty;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed, table-driven self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        clear;
    logic        id_valid;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_halt;
    logic        ex_branch_taken;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel_branch;
    logic [1:0]  fwd_a, fwd_b;
    logic        halted;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    // ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel_branch}
    localparam logic [4:0] N  = 5'b11000;  // free-running
    localparam logic [4:0] ST = 5'b00010;  // stall / drain / halted
    localparam logic [4:0] BR = 5'b11111;  // taken branch
    localparam logic [4:0] HI = 5'b00000;  // halt issuing
    localparam logic [4:0] RS = 5'b00110;  // in reset

    typedef struct {
        logic       v;
        logic [3:0] rs, rt, rd;
        logic       urs, urt, rw, mr, hlt, br;
        logic [4:0] ctl;
        logic [1:0] fa, fb;
        logic       h;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [28];

    hazard_ctrl dut (
        .clk             (clk),
        .clear           (clear),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .id_halt         (id_halt),
        .ex_branch_taken (ex_branch_taken),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pc_sel_branch   (pc_sel_branch),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                                input logic [3:0] rd, input logic urs, input logic urt,
                                input logic rw, input logic mr, input logic hlt, input logic br,
                                input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                                input logic h, input logic [15:0] cnt);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.urs = urs; t.urt = urt;
        t.rw = rw; t.mr = mr; t.hlt = hlt; t.br = br;
        t.ctl = ctl; t.fa = fa; t.fb = fb; t.h = h; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [4:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic h, input logic [15:0] cnt);
        logic [4:0] act;
        act = {pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel_branch};
        n_cmp++;
        if (act !== ctl || fwd_a !== fa || fwd_b !== fb || halted !== h || stall_count !== cnt) begin
            n_bad++;
            $display("FAIL %s: got ctl=%b fwd_a=%b fwd_b=%b halted=%b cnt=%0d, expected ctl=%b fwd_a=%b fwd_b=%b halted=%b cnt=%0d",
                     name, act, fwd_a, fwd_b, halted, stall_count, ctl, fa, fb, h, cnt);
        end
    endtask

    // Called just after a rising edge: drive one cycle, check mid-cycle, move to the next edge.
    task automatic run_vec(input vec_t t, input string name);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
        id_uses_rs = t.urs; id_uses_rt = t.urt; id_regwrite = t.rw;
        id_memread = t.mr; id_halt = t.hlt; ex_branch_taken = t.br;
        @(negedge clk);
        chk(name, t.ctl, t.fa, t.fb, t.h, t.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0, N,0,0,0,0);

        // ALU forwarding: adjacent, one between, two between
        tbl[0]  = mk(1,0,0,1,  0,0,1,0,0,0, N,0,0,0,0);
        tbl[1]  = mk(1,1,3,4,  1,0,1,0,0,0, N,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,  0,0,0,0,0,0, N,1,0,0,0);
        tbl[3]  = mk(1,0,0,5,  0,0,1,0,0,0, N,0,0,0,0);
        tbl[4]  = mk(1,7,0,6,  1,0,1,0,0,0, N,0,0,0,0);
        tbl[5]  = mk(1,5,0,0,  1,0,0,0,0,0, N,0,0,0,0);
        tbl[6]  = mk(0,0,0,0,  0,0,0,0,0,0, N,2,0,0,0);
        tbl[7]  = mk(1,0,0,8,  0,0,1,0,0,0, N,0,0,0,0);
        tbl[8]  = mk(1,0,0,9,  0,0,1,0,0,0, N,0,0,0,0);
        tbl[9]  = mk(1,0,0,10, 0,0,1,0,0,0, N,0,0,0,0);
        tbl[10] = mk(1,8,9,0,  1,1,0,0,0,0, N,0,0,0,0);
        tbl[11] = mk(0,0,0,0,  0,0,0,0,0,0, N,0,2,0,0);
        // load-use: one stall, then MEM/WB forward on rt
        tbl[12] = mk(1,0,0,2,  0,0,1,1,0,0, N,0,0,0,0);
        tbl[13] = mk(1,0,2,0,  0,1,0,0,0,0, ST,0,0,0,0);
        tbl[14] = mk(1,0,2,0,  0,1,0,0,0,0, N,0,0,0,1);
        tbl[15] = mk(0,0,0,0,  0,0,0,0,0,0, N,0,2,0,1);
        // branch coincident with a load-use hazard
        tbl[16] = mk(1,0,0,3,  0,0,1,1,0,0, N,0,0,0,1);
        tbl[17] = mk(1,3,0,0,  1,0,0,0,0,1, BR,0,0,0,1);
        tbl[18] = mk(0,0,0,0,  0,0,0,0,0,0, N,0,0,0,1);
        // register 0 loaded then consumed: no stall, no forward
        tbl[19] = mk(1,0,0,0,  0,0,1,1,0,0, N,0,0,0,1);
        tbl[20] = mk(1,0,0,0,  1,1,0,0,0,0, N,0,0,0,1);
        tbl[21] = mk(0,0,0,0,  0,0,0,0,0,0, N,0,0,0,1);
        // halt issue at t, halted visible at t+4 and held
        tbl[22] = mk(1,0,0,0,  0,0,0,0,1,0, HI,0,0,0,1);
        tbl[23] = mk(1,1,2,3,  1,1,1,0,0,0, ST,0,0,0,1);
        tbl[24] = mk(1,1,2,3,  1,1,1,0,0,0, ST,0,0,0,1);
        tbl[25] = mk(1,1,2,3,  1,1,1,0,0,0, ST,0,0,0,1);
        tbl[26] = mk(1,1,2,3,  1,1,1,0,0,0, ST,0,0,1,1);
        tbl[27] = mk(1,1,2,3,  1,1,1,0,0,1, ST,0,0,1,1);

        clear = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_regwrite = 0; id_memread = 0; id_halt = 0; ex_branch_taken = 0;
        #2;
        chk("reset_initial", RS, 0, 0, 0, 0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 28; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset out of HALT takes effect without a clock edge
        #2;
        clear = 1'b0;
        #1;
        chk("reset_from_halt", RS, 0, 0, 0, 0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;

        // Load-use stall into a halt, then reset in the middle of the drain
        run_vec(mk(1,0,0,1, 0,0,1,1,0,0, N,0,0,0,0), "seq_load");
        run_vec(mk(1,1,0,0, 1,0,0,0,1,0, ST,0,0,0,0), "seq_halt_stalled");
        run_vec(mk(1,1,0,0, 1,0,0,0,1,0, HI,0,0,0,1), "seq_halt_issue");
        id_halt = 1'b0;
        @(negedge clk);
        chk("seq_drain", ST, 2, 0, 0, 1);
        #2;
        clear = 1'b0;
        #1;
        chk("reset_mid_drain", RS, 0, 0, 0, 0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;

        // Taken branch during drain returns to normal running
        run_vec(mk(1,0,0,0, 0,0,0,0,1,0, HI,0,0,0,0), "drain_halt_issue");
        run_vec(mk(1,0,0,0, 0,0,0,0,0,1, BR,0,0,0,0), "drain_branch");
        run_vec(idle, "drain_back_run");
        run_vec(idle, "drain_back_run2");
        run_vec(idle, "drain_back_run3");
        run_vec(idle, "drain_no_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
